// File: rtl/pipe_pkg.sv
// Shared types and per-stage widths for the RV32IM inter-stage skid registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int PERF_CNT_W = 32;

  localparam int IF_ID_DATA_W  = 96;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 160;
  localparam int ID_EX_CTRL_W  = 19;
  localparam int EX_MEM_DATA_W = 96;
  localparam int EX_MEM_CTRL_W = 12;
  localparam int MEM_WB_DATA_W = 64;
  localparam int MEM_WB_CTRL_W = 7;

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffer entry (valid, data, ctrl) with load and clear; clear wins and zeroes ctrl only.
module pipe_entry_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 19
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the data field is reset too because out_data is visible and must read 0 after reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer and flush.
// Optional PIPE_STAGE_SKID_PERF_EN adds saturating stall/flush counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int CTRL_W = ID_EX_CTRL_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush
`ifdef PIPE_STAGE_SKID_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

  pipe_state_e r_state, w_next_state;

  logic              w_accept, w_drain;
  logic              w_main_load, w_main_clear, w_main_from_skid;
  logic              w_skid_load, w_skid_clear;
  logic              w_main_valid, w_skid_valid;
  logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_d_data;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_d_ctrl;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = w_main_valid & out_ready;

  always_ff @(posedge CLK) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_next_state;
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next_state     = r_state;
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_next_state = EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      unique case (r_state)
        EMPTY: if (w_accept) begin
          w_main_load  = 1'b1;
          w_next_state = ONE;
        end
        ONE: begin
          if (w_accept && w_drain) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load  = 1'b1;
            w_next_state = TWO;
          end else if (w_drain) begin
            w_main_clear = 1'b1;
            w_next_state = EMPTY;
          end
        end
        TWO: if (w_drain) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_skid_clear     = 1'b1;
          w_next_state     = ONE;
        end
        default: w_next_state = EMPTY;
      endcase
    end
  end

  assign w_main_d_data = w_main_from_skid ? w_skid_data : in_data;
  assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .CLK     (CLK),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_d_data),
    .i_ctrl  (w_main_d_ctrl),
    .o_valid (w_main_valid),
    .o_data  (w_main_data),
    .o_ctrl  (w_main_ctrl)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .CLK     (CLK),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (in_data),
    .i_ctrl  (in_ctrl),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_ctrl  (w_skid_ctrl)
  );

  // in_ready comes straight from the skid flop, so out_ready/flush never reach it combinationally.
  assign in_ready  = ~w_skid_valid;
  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;

`ifdef PIPE_STAGE_SKID_PERF_EN
  localparam logic [PERF_CNT_W-1:0] CNT_ONE = 1;

  logic [PERF_CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_main_valid && !out_ready && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (flush && (w_main_valid || r_state == TWO) && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (perf checks when PIPE_STAGE_SKID_PERF_EN is set).
module tb_pipe_stage_skid;

  localparam int DW = 160;
  localparam int CW = 19;

  logic          CLK = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          flush;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   flush_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush     (flush)
`ifdef PIPE_STAGE_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input int d, input int c);
    in_valid = v;
    in_data  = DW'(d);
    in_ctrl  = CW'(c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 'hAA, 'h7FFFF);
    tick(); tick();
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_ctrl",  DW'(out_ctrl),  DW'(0));
    check("rst_out_data",  out_data,       DW'(0));
    check("rst_in_ready",  DW'(in_ready),  DW'(1));

    // First accept after reset release appears one cycle later
    reset = 1'b0;
    drive(1'b1, 'h11, 'h3);
    check("pre_accept_invalid", DW'(out_valid), DW'(0));
    tick();
    check("first_valid", DW'(out_valid), DW'(1));
    check("first_data",  out_data,       DW'('h11));
    check("first_ctrl",  DW'(out_ctrl),  DW'(3));

    // Streaming 1..4
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, i);
      tick();
      check($sformatf("stream_data_%0d", i), out_data, DW'(i));
      check($sformatf("stream_ready_%0d", i), DW'(in_ready), DW'(1));
    end
    drive(1'b0, 0, 0);
    tick();
    check("stream_end_valid", DW'(out_valid), DW'(0));
    check("stream_end_ctrl",  DW'(out_ctrl),  DW'(0));

    // Backpressure: 5 in main, 6 to skid, 7 held
    drive(1'b1, 5, 5);
    tick();
    check("bp_main5", out_data, DW'(5));
    out_ready = 1'b0;
    drive(1'b1, 6, 6);
    tick();
    check("bp_two_ready", DW'(in_ready), DW'(0));
    check("bp_two_data",  out_data,      DW'(5));
    drive(1'b1, 7, 7);
    tick();
    check("bp_hold_data",  out_data,      DW'(5));
    check("bp_hold_ctrl",  DW'(out_ctrl), DW'(5));
    check("bp_hold_ready", DW'(in_ready), DW'(0));
    out_ready = 1'b1;
    tick();
    check("bp_out6",   out_data,      DW'(6));
    check("bp_ready1", DW'(in_ready), DW'(1));
    tick();
    check("bp_out7",   out_data,       DW'(7));
    check("bp_valid7", DW'(out_valid), DW'(1));
    drive(1'b0, 0, 0);
    tick();
    check("bp_no_dup", DW'(out_valid), DW'(0));

    // Flush in TWO drops 8, 9 and the concurrent 10
    out_ready = 1'b0;
    drive(1'b1, 8, 8);
    tick();
    drive(1'b1, 9, 9);
    tick();
    check("fl_two", DW'(in_ready), DW'(0));
    flush = 1'b1;
    drive(1'b1, 10, 10);
    tick();
    check("fl_valid", DW'(out_valid), DW'(0));
    check("fl_ctrl",  DW'(out_ctrl),  DW'(0));
    check("fl_ready", DW'(in_ready),  DW'(1));
    check("fl_data_kept", out_data,   DW'(8));
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 0, 0);
    tick();
    check("fl_nothing_after", DW'(out_valid), DW'(0));

    // Simultaneous accept/drain in ONE, then bubble
    drive(1'b1, 'h20, 2);
    tick();
    drive(1'b1, 'h21, 1);
    tick();
    check("ad_data", out_data,      DW'('h21));
    check("ad_ctrl", DW'(out_ctrl), DW'(1));
    drive(1'b0, 0, 0);
    tick();
    check("bub_valid", DW'(out_valid), DW'(0));
    check("bub_ctrl",  DW'(out_ctrl),  DW'(0));
    check("bub_data",  out_data,       DW'('h21));

`ifdef PIPE_STAGE_SKID_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("perf_rst_stall", DW'(stall_cnt), DW'(0));
    check("perf_rst_flush", DW'(flush_cnt), DW'(0));
    out_ready = 1'b0;
    drive(1'b1, 'h30, 1);
    tick();
    drive(1'b0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    check("perf_stall5", DW'(stall_cnt), DW'(5));
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b1, 'h31, 1);
    tick();
    drive(1'b0, 0, 0);
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    check("perf_flush2", DW'(flush_cnt), DW'(2));
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    out_ready = 1'b0;
    drive(1'b1, 'h32, 1);
    tick();
    drive(1'b0, 0, 0);
    tick(); tick(); tick();
    check("perf_stall_sat", DW'(stall_cnt), DW'(32'hFFFF_FFFF));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RV32IM pipeline.
- Carries one opaque data payload and one control payload per instruction.
- Uses valid/ready handshaking with a 2-entry skid buffer, so in_ready is registered and never depends combinationally on out_ready.
- Supports a flush input for branch/jump redirects, and forces control bits to zero on every bubble so downstream write enables are never spurious.

Parameters:
- DATA_W, 160, width of the data payload (pc, pc+4, data1, data2, immediate for ID/EX).
- CTRL_W, 19, width of the control payload (write_addr, aluop, branch_jump, op/wb selects, mem_read/mem_write, reg_write_en).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream stage presents a valid instruction.
- in_ready  output  1  stage can accept; registered (equals "skid entry empty").
- in_data  input  DATA_W  upstream data payload.
- in_ctrl  input  CTRL_W  upstream control payload.
- out_valid  output  1  main entry holds a valid instruction.
- out_ready  input  1  downstream accepts this cycle (deasserted by the stage on memory busywait).
- out_data  output  DATA_W  main entry data.
- out_ctrl  output  CTRL_W  main entry control; all zero whenever out_valid=0.
- flush  input  1  discard all held and incoming instructions this cycle.

Behaviour:
- Interface: clock CLK; reset is reset, synchronous, active-high.
- Reset values: out_valid=0, out_data=0, out_ctrl=0, in_ready=1, state EMPTY. Reset has priority over flush, and flush has priority over accept.
- Transfer definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- States:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: main valid, skid valid, in_ready=0.
- Transitions when there is no flush:
  - EMPTY, accept: load main -> ONE.
  - ONE, accept & drain: load main -> ONE.
  - ONE, accept & !drain: load skid -> TWO.
  - ONE, !accept & drain -> EMPTY.
  - TWO, drain: skid moves to main -> ONE. No accept is possible in TWO.
  - All other cases hold state.
- Flush: next state EMPTY and out_valid=0. out_ctrl is zeroed; out_data keeps its last value. An input presented in the same cycle is dropped even if in_ready=1. in_ready=1 the following cycle.
- Latency and throughput:
  - Accept in EMPTY or ONE(drain) -> out_valid=1 with that payload on the next cycle.
  - Sustained throughput is 1 per cycle while out_ready=1.
- Ordering: strict FIFO. A skid entry is never overtaken by a new input.
- Bubbles: whenever out_valid=0, out_ctrl=0 regardless of stored contents.
- Hold behaviour: while out_ready=0, out_data and out_ctrl are stable. While in TWO, skid contents are stable.
- No combinational path from out_ready or flush to in_ready.

Optional Feature:
- Macro: PIPE_STAGE_SKID_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1 while out_valid=1 or the stage is in TWO (i.e. instructions were discarded).
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef of the state enum (EMPTY/ONE/TWO);
  - localparam PERF_CNT_W=32;
  - per-stage width constants (ID_EX_DATA_W=160, ID_EX_CTRL_W=19, etc.) so the four stages instantiate pipe_stage_skid by constant.
- One sub-module: pipe_entry_reg, a single entry (valid, data, ctrl) with load/clear inputs and synchronous reset, instantiated twice (main, skid).

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, in_ctrl=19'h7FFFF -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1; first accept after release appears 1 cycle later.
- Streaming: out_ready=1, feed data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the next four cycles, in_ready stays 1.
- Backpressure: out_ready=0 after data 5 lands in main; send 6 -> state TWO, in_ready=0, in_valid with 7 held. Release out_ready -> outputs 5,6,7 in order, 7 neither lost nor duplicated.
- Flush in TWO: main=8, skid=9, flush=1 with in_valid=1 data 10 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 8, 9, 10 never appear.
- Simultaneous accept/drain in ONE with ctrl=19'h00001 then bubble -> ctrl 1 for one cycle, then out_ctrl=0 while out_data retains its value.
- Perf (PIPE_STAGE_SKID_PERF_EN): 5 stall cycles and 2 flushes of valid stages -> stall_cnt=5, flush_cnt=2; force stall_cnt to 32'hFFFFFFFE plus 3 stalls -> 32'hFFFFFFFF.
